// File: rtl/rgbled_ws281x_tx.sv
// WS281x single-wire NRZ encoder: serialises 24-bit pixels MSB-first and
// closes each frame with a low latch gap on dout_o.
module rgbled_ws281x_tx #(
    parameter int T0HCycles   = 20,
    parameter int T1HCycles   = 40,
    parameter int BitCycles   = 63,
    parameter int LatchCycles = 4000
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        go_i,
    output logic        idle_o,
    input  logic [23:0] data_i,
    input  logic        data_valid_i,
    input  logic        data_last_i,
    output logic        data_ack_o,
    output logic        dout_o,
    output logic [1:0]  state_dbg_o
);

    localparam int CycW = $clog2(BitCycles + 1);
    localparam int LatW = $clog2(LatchCycles + 1);
    localparam logic [CycW-1:0] CycLast = CycW'(BitCycles - 1);
    localparam logic [CycW-1:0] T0High  = CycW'(T0HCycles);
    localparam logic [CycW-1:0] T1High  = CycW'(T1HCycles);
    localparam logic [LatW-1:0] LatLast = LatW'(LatchCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [23:0]       shift_q, shift_d;
    logic              last_q, last_d;
    logic [4:0]        bit_q, bit_d;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic [LatW-1:0]   lat_q, lat_d;
    logic              dout_q, dout_d;
    logic              ack;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            last_q  <= 1'b0;
            bit_q   <= '0;
            cyc_q   <= '0;
            lat_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            lat_q   <= lat_d;
            dout_q  <= dout_d;
        end
    end

    // Handshake: data_valid_i/data_i/data_last_i are held by the source until
    // data_ack_o is high in a cycle; the pixel is taken at the end of that cycle.
    // Acks happen only in IDLE (with go_i) or in the final cycle of bit 23.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        last_d  = last_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        lat_d   = lat_q;
        ack     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (go_i && data_valid_i) begin
                    ack     = 1'b1;
                    shift_d = data_i;
                    last_d  = data_last_i;
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cyc_q == CycLast) begin
                    cyc_d = '0;
                    if (bit_q == 5'd23) begin
                        if (!last_q && data_valid_i) begin
                            ack     = 1'b1;
                            shift_d = data_i;
                            last_d  = data_last_i;
                            bit_d   = '0;
                        end else begin
                            // Either the frame is complete or the source ran dry.
                            lat_d   = '0;
                            state_d = ST_LATCH;
                        end
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q + 5'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            ST_LATCH: begin
                if (lat_q == LatLast) begin
                    lat_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The line level is registered, so it is derived from the next state.
        dout_d = (state_d == ST_SEND) && (cyc_d < (shift_d[23] ? T1High : T0High));
    end

    // Gated by reset so the ack cannot pulse while the flops are held.
    assign data_ack_o  = ack && rst_sys_n;
    assign dout_o      = dout_q;
    assign idle_o      = (state_q == ST_IDLE);
    assign state_dbg_o = state_q;

endmodule

// File: doc/rgbled_ws281x_tx.md
# rgbled_ws281x_tx

Serial line encoder for WS2812/WS281x chained RGB LEDs. It consumes 24-bit pixel words over a valid/ack handshake from the colour sequencer in the Sonata top level and drives the single-wire NRZ LED data line with a latch gap after each frame. It sits between the pixel source and the board pin; any inversion for the level shifter is applied outside this block.

## Interface
Parameters:
- T0HCycles, 20: high time of a '0' bit, in clk_sys cycles (0.4 µs at 50 MHz).
- T1HCycles, 40: high time of a '1' bit (0.8 µs).
- BitCycles, 63: total bit period (1.26 µs).
- LatchCycles, 4000: low time after a frame (80 µs).
- Legal range: 0 < T0HCycles < T1HCycles < BitCycles; LatchCycles ≥ 1.
- Counter widths come from $clog2 of the largest count.

Ports:
- clk_sys  in  1  system clock.
- rst_sys_n  in  1  reset: asynchronous, active-low.
- go_i  in  1  permission to start a frame; sampled only in IDLE.
- idle_o  out  1  high only in IDLE.
- data_i  in  24  pixel word; bit 23 is sent first. Channel order (GRB) is the source's responsibility.
- data_valid_i  in  1  data_i/data_last_i are valid.
- data_last_i  in  1  this pixel ends the frame.
- data_ack_o  out  1  one-cycle pulse; the pixel was captured this cycle.
- dout_o  out  1  LED data line, registered, active-high.

## Operation
- State machine: IDLE, SEND, LATCH.
- IDLE: dout_o=0, idle_o=1.
  - If go_i && data_valid_i: capture data_i into shift_q and data_last_i into last_q, pulse data_ack_o, clear bit_cnt (0..23) and cyc_cnt (0..BitCycles-1), go to SEND.
  - Otherwise stay.
- SEND: dout_o high while cyc_cnt < (shift_q[23] ? T1HCycles : T0HCycles), else low.
  - cyc_cnt wraps at BitCycles-1; on wrap, shift_q shifts left by 1 and bit_cnt increments.
- End of bit 23 (bit_cnt==23 && cyc_cnt==BitCycles-1):
  - last_q=1 → LATCH.
  - last_q=0 and data_valid_i=1 → capture the next pixel, pulse data_ack_o, stay in SEND. The next bit starts on the following cycle with no gap.
  - last_q=0 and data_valid_i=0 (underrun) → LATCH. The frame ends early.
- LATCH: dout_o=0 for exactly LatchCycles cycles, then IDLE.
- data_ack_o is never asserted outside the two capture points above. data_valid_i without an ack must be held by the source.
- go_i and data_valid_i are ignored in SEND except at the bit-23 capture point. go_i is ignored in LATCH.

## Timing
- Reset values: dout_o=0, idle_o=1, data_ack_o=0, state IDLE, all counters 0.
- Reset asserted mid-frame: outputs return to reset values immediately (async). The line stays low, which acts as a latch.
- Start latency: ack in cycle N (IDLE). idle_o=0 and dout_o=1 from cycle N+1.
- Each bit lasts exactly BitCycles cycles, and each pixel lasts exactly 24·BitCycles = 1512 cycles.
- Chained pixel: ack in the last cycle of bit 23. The first bit of the new pixel rises in the next cycle.
- Frame end: dout_o=0 for LatchCycles cycles starting the cycle after the last bit's final cycle. idle_o=1 on the following cycle.
- Bit waveforms: '1' is high for exactly T1HCycles then low for BitCycles-T1HCycles. '0' is high for T0HCycles then low for the remainder.
- A data_valid_i drop while no ack is pending has no effect.

## Test plan
- Single pixel 0xA5_00_FF, last=1, go=1:
  - one ack pulse;
  - dout_o shows 24 bits MSB-first;
  - high times are 40/20/40/20/20/40/20/40, then 8×20, then 8×40 cycles;
  - each period is 63 cycles;
  - then 4000 low cycles, then idle_o=1.
- Three-pixel frame (last on the third), valid held high:
  - acks exactly 1512 cycles apart;
  - no gap between pixels;
  - one latch only after pixel 3.
- Underrun: pixel 1 last=0, valid dropped before bit 23 ends:
  - LATCH entered right after pixel 1;
  - no second ack;
  - idle_o=1 after 4000 cycles.
- go_i=0 with valid=1 for 100 cycles:
  - no ack, dout_o=0, idle_o=1.
  - Raising go_i gives an ack the same cycle and dout_o=1 the next.
- Reset asserted in cycle 700 of a pixel:
  - dout_o=0, idle_o=1, data_ack_o=0 immediately.
  - After release, a new pixel starts cleanly from bit 23.
- Parameter override T0H=2, T1H=4, Bit=6, Latch=3:
  - pixel 0x800000 gives 4 high cycles, 2 low, then 23 × (2 high, 4 low), then 3 low cycles.
